// File: rtl/dmem_responder_if.sv
// Load/store bus between the MEM stage (master) and the data-memory
// responder (slave). The MEM stage drives the request; the responder
// returns read data, completion, error and the pipeline stall/busy flags.
interface dmem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              err;
    logic              stall;
    logic              busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, err, stall, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, err, stall, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Slow data-memory responder for the 8-bit pipelined processor.
// A request is sampled only in IDLE, held for WAIT_CYCLES wait states, and
// completed on the edge that enters RESP: the write is committed or the read
// data is loaded, and a one-cycle ack (with err for out-of-range addresses)
// is raised. stall holds the pipeline while a request is outstanding.
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit              ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0]      WAIT_M1   = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);
    // One extra bit so DEPTH = 2^ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              r_ack;
    logic              r_err;

    logic              w_commit;
    logic              w_src_we;
    logic [ADDR_W-1:0] w_src_addr;
    logic [DATA_W-1:0] w_src_wdata;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;

    // Select the request being completed: with zero wait states the RESP-entry
    // edge is the acceptance edge, so the live bus values are used directly.
    always_comb begin
        w_commit    = 1'b0;
        w_src_we    = r_we;
        w_src_addr  = r_addr;
        w_src_wdata = r_wdata;
        if (r_state == S_IDLE) begin
            w_src_we    = bus.we;
            w_src_addr  = bus.addr;
            w_src_wdata = bus.wdata;
            w_commit    = ZERO_WAIT && bus.req;
        end else if (r_state == S_WAIT) begin
            w_commit    = (r_cnt == 4'd0);
        end
        w_in_range = ({1'b0, w_src_addr} < DEPTH_LIM);
        w_idx      = w_src_addr[IDX_W-1:0];
    end

    // Request sequencing: accept in IDLE, count wait states, single RESP cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        if (ZERO_WAIT) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WAIT_M1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Completion: commit write or load read data, pulse ack/err for one cycle.
    // Out-of-range writes are dropped and out-of-range reads return zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (w_commit) begin
                r_ack <= 1'b1;
                r_err <= ~w_in_range;
                if (w_src_we) begin
                    if (w_in_range) begin
                        r_mem[w_idx] <= w_src_wdata;
                    end
                end else begin
                    r_rdata <= w_in_range ? r_mem[w_idx] : '0;
                end
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.stall = bus.req & ~r_ack;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a driver issues directed and random load/store
// transactions, a reference model predicts ack timing, err and read data into
// a scoreboard queue, and a negedge monitor compares the DUT against it.
module tb_dmem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dmem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();
    dmem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();

    dmem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    dmem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state
    typedef struct {
        int         cyc;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_mem [256];
    logic [7:0] last_rd;
    int cur_lo = -10, cur_hi = -10, prev_lo = -10, prev_hi = -10;
    int cur_ack = -10, prev_ack = -10;
    bit at_ack  = 1'b0;
    bit run_mon = 1'b0;

    task automatic model_clear();
        sb.delete();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        last_rd  = 8'h00;
        cur_lo   = -10; cur_hi  = -10; prev_lo = -10; prev_hi = -10;
        cur_ack  = -10; prev_ack = -10;
        at_ack   = 1'b0;
    endtask

    // Present a request (called at posedge+1) and record the expected result.
    task automatic start(input bit w, input logic [7:0] a, input logic [7:0] d);
        int   n;
        exp_t e;
        n = at_ack ? cyc + 1 : cyc;   // in the ack cycle the FSM is still in RESP
        bus2.req   = 1'b1;
        bus2.we    = w;
        bus2.addr  = a;
        bus2.wdata = d;
        prev_lo  = cur_lo;  prev_hi = cur_hi; prev_ack = cur_ack;
        cur_lo   = n + 1;   cur_hi  = n + W + 1; cur_ack = n + W + 1;
        e.cyc = n + W + 1;
        e.err = (int'(a) >= DEPTH);
        if (w) begin
            if (!e.err) ref_mem[a] = d;
        end else begin
            last_rd = e.err ? 8'h00 : ref_mem[a];
        end
        e.rdata = last_rd;
        sb.push_back(e);
        at_ack = 1'b0;
    endtask

    task automatic wait_ack(input bit scramble);
        int n;
        n = cur_ack - W - 1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (bus2.ack) begin
                at_ack = 1'b1;
                break;
            end
            if (scramble && cyc > n) begin
                bus2.addr  = 8'($urandom);
                bus2.wdata = 8'($urandom);
                bus2.we    = 1'($urandom);
            end
        end
        chk("ack_seen", {31'd0, at_ack}, 32'd1);
    endtask

    task automatic txn(input bit w, input logic [7:0] a, input logic [7:0] d,
                       input bit scramble, input bit b2b);
        start(w, a, d);
        wait_ack(scramble);
        if (!b2b) begin
            bus2.req   = 1'b0;
            bus2.addr  = 8'($urandom);
            bus2.wdata = 8'($urandom);
            @(posedge clock); #1;
            at_ack = 1'b0;
        end
    endtask

    task automatic do_reset();
        bus2.req = 1'b0;
        reset    = 1'b1;
        model_clear();
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    // Monitor: compares the DUT each cycle against the model's schedule.
    always @(negedge clock) begin
        if (!reset && run_mon) begin
            logic exp_ack, exp_stall, exp_busy;
            exp_t e;
            while (sb.size() != 0 && sb[0].cyc < cyc) void'(sb.pop_front());
            exp_ack   = (sb.size() != 0) && (sb[0].cyc == cyc);
            exp_stall = bus2.req && (cyc != cur_ack) && (cyc != prev_ack);
            exp_busy  = (cyc >= cur_lo && cyc <= cur_hi) || (cyc >= prev_lo && cyc <= prev_hi);
            chk("stall", {31'd0, bus2.stall}, {31'd0, exp_stall});
            chk("busy",  {31'd0, bus2.busy},  {31'd0, exp_busy});
            chk("ack",   {31'd0, bus2.ack},   {31'd0, exp_ack});
            if (exp_ack) begin
                e = sb.pop_front();
                chk("err",   {31'd0, bus2.err}, {31'd0, e.err});
                chk("rdata", {24'd0, bus2.rdata}, {24'd0, e.rdata});
            end else begin
                chk("err_idle", {31'd0, bus2.err}, 32'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.wdata = '0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ack",   {31'd0, bus2.ack},   32'd0);
        chk("rst_err",   {31'd0, bus2.err},   32'd0);
        chk("rst_busy",  {31'd0, bus2.busy},  32'd0);
        chk("rst_rdata", {24'd0, bus2.rdata}, 32'd0);
        chk("rst0_busy", {31'd0, bus0.busy},  32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        run_mon = 1'b1;

        // Preload address 5 with a committed value, then abort a write mid-WAIT.
        txn(1'b1, 8'd5, 8'h33, 1'b0, 1'b0);
        start(1'b1, 8'd5, 8'hAA);
        @(posedge clock); #1;
        chk("rst_mid_busy", {31'd0, bus2.busy}, 32'd1);
        do_reset();
        txn(1'b0, 8'd5, 8'h00, 1'b0, 1'b0);

        // Basic write then read
        txn(1'b1, 8'd3, 8'h5C, 1'b0, 1'b0);
        txn(1'b0, 8'd3, 8'h00, 1'b0, 1'b0);

        // Back-to-back write then read
        txn(1'b1, 8'd1, 8'h11, 1'b0, 1'b1);
        txn(1'b0, 8'd1, 8'h00, 1'b0, 1'b0);

        // Out-of-range accesses and an in-range neighbour
        txn(1'b1, 8'd8,  8'h22, 1'b0, 1'b0);
        txn(1'b1, 8'd40, 8'hFF, 1'b0, 1'b0);
        txn(1'b0, 8'd40, 8'h00, 1'b0, 1'b0);
        txn(1'b0, 8'd8,  8'h00, 1'b0, 1'b0);

        // Inputs scrambled during WAIT are ignored
        txn(1'b1, 8'd2, 8'h7E, 1'b1, 1'b0);
        txn(1'b0, 8'd2, 8'h00, 1'b0, 1'b0);
        txn(1'b0, 8'd3, 8'h00, 1'b0, 1'b0);
        txn(1'b0, 8'd1, 8'h00, 1'b0, 1'b0);

        // Random traffic
        for (int t = 0; t < 150; t++) begin
            bit b2b;
            b2b = (t != 149) && ($urandom_range(0, 2) == 0);
            txn(1'($urandom), 8'($urandom_range(0, 39)), 8'($urandom), 1'($urandom), b2b);
            if (!b2b) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clock); #1;
                end
            end
        end

        // Zero-wait instance
        @(posedge clock); #1;
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 8'd3; bus0.wdata = 8'h5C;
        @(negedge clock);
        chk("z_wr_stall", {31'd0, bus0.stall}, 32'd1);
        @(posedge clock); #1;
        bus0.req = 1'b0;
        @(negedge clock);
        chk("z_wr_ack", {31'd0, bus0.ack}, 32'd1);
        chk("z_wr_err", {31'd0, bus0.err}, 32'd0);
        @(posedge clock); #1;
        bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 8'd3; bus0.wdata = 8'h00;
        @(negedge clock);
        chk("z_rd_stall0", {31'd0, bus0.stall}, 32'd1);
        chk("z_rd_busy0",  {31'd0, bus0.busy},  32'd0);
        chk("z_rd_ack0",   {31'd0, bus0.ack},   32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("z_rd_ack1",   {31'd0, bus0.ack},   32'd1);
        chk("z_rd_busy1",  {31'd0, bus0.busy},  32'd1);
        chk("z_rd_stall1", {31'd0, bus0.stall}, 32'd0);
        chk("z_rd_rdata",  {24'd0, bus0.rdata}, 32'h5C);
        #2;
        bus0.req = 1'b0;
        @(negedge clock);
        chk("z_rd_ack2",  {31'd0, bus0.ack},  32'd0);
        chk("z_rd_busy2", {31'd0, bus0.busy}, 32'd0);

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
